quad_steer_decoder: RTL and testbench



---
 rtl/quad_pkg.sv | 36 +++
 rtl/quad_sync_filter.sv | 85 ++++++++
 rtl/quad_steer_decoder.sv | 154 +++++++++++++++
 tb/tb_quad_steer_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// ----------------------------------------------------------------------------
// quad_pkg
// Shared types and helpers for the quadrature steering decoder.
//   quad_t     : 2-bit phase state, packed as {A,B}
//   step_t     : classification of one prev->cur phase change
//   DIR_LEFT / DIR_RIGHT : encoding of the dir output
//   quad_step(): classifies a prev->cur transition
// ----------------------------------------------------------------------------
package quad_pkg;

    typedef logic [1:0] quad_t;

    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_FWD     = 2'd1,
        STEP_REV     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Forward (right) order is 00 -> 01 -> 11 -> 10 -> 00. Any change of a
    // single bit is either one position forward or one back; a change of
    // both bits skips a state and cannot be attributed to a direction.
    function automatic step_t quad_step(input quad_t prev, input quad_t cur);
        quad_step = STEP_NONE;
        case ({prev, cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: quad_step = STEP_FWD;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: quad_step = STEP_REV;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: quad_step = STEP_ILLEGAL;
            default:                                quad_step = STEP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// ----------------------------------------------------------------------------
// quad_sync_filter
// One phase input: 2-flop synchronizer, optionally followed by a stability
// filter (build with QUAD_FILTER_EN defined).
// Ports:
//   CLK    in  clock
//   reset  in  asynchronous active-high reset
//   din    in  raw phase input, asynchronous to CLK
//   dout   out synchronized (and, if enabled, filtered) phase level
//   valid  out dout carries a real sample of din (not the reset value)
// Parameter FILT_CYCLES exists only when QUAD_FILTER_EN is defined.
// ----------------------------------------------------------------------------
module quad_sync_filter #(
`ifdef QUAD_FILTER_EN
    parameter int FILT_CYCLES = 4
`endif
) (
    input  logic CLK,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic valid
);

    logic       sync_1;
    logic       sync_2;
    logic [1:0] fill;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the two synchronizer stages into one.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            fill   <= 2'b00;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            // fill[1] rises once sync_2 holds a sampled value, so the reset
            // zeros are never mistaken for a real phase level.
            fill   <= {fill[0], 1'b1};
        end
    end

`ifdef QUAD_FILTER_EN
    localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

    logic          filt_q;
    logic          loaded;
    logic [CW-1:0] stable_cnt;

    // stable_cnt counts consecutive cycles in which the synchronized bit
    // differs from the filtered output. Returning to the output value (a
    // glitch) restarts the count. The first valid sample is taken as-is so
    // the filter starts from the real input level.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            filt_q     <= 1'b0;
            loaded     <= 1'b0;
            stable_cnt <= '0;
        end else if (fill[1]) begin
            if (!loaded) begin
                filt_q     <= sync_2;
                loaded     <= 1'b1;
                stable_cnt <= '0;
            end else if (sync_2 == filt_q) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(FILT_CYCLES - 1)) begin
                filt_q     <= sync_2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

    assign dout  = filt_q;
    assign valid = loaded;
`else
    assign dout  = sync_2;
    assign valid = fill[1];
`endif

endmodule

// File: rtl/quad_steer_decoder.sv
// ----------------------------------------------------------------------------
// quad_steer_decoder
// Receives the A/B steering quadrature pair, tracks a wrapping position,
// flags illegal (two-bit) transitions and regenerates held left/right levels.
// Optional input stability filter: define QUAD_FILTER_EN (adds parameter
// FILT_CYCLES).
// Parameters:
//   POS_W        width of the position counter (two's complement, wraps)
//   HOLD_CYCLES  cycles left/right stay asserted after the last step (>= 1)
//   FILT_CYCLES  stable cycles required per bit (QUAD_FILTER_EN only)
// Ports:
//   CLK      in  clock
//   reset    in  asynchronous active-high reset
//   quad_a   in  phase A (async)
//   quad_b   in  phase B (async)
//   clr_err  in  synchronous clear of err
//   pos      out accumulated signed step count
//   step     out one-cycle pulse per valid step
//   dir      out direction of the last valid step (1 = right, 0 = left)
//   err      out sticky illegal-transition flag
//   left     out held left level
//   right    out held right level
// ----------------------------------------------------------------------------
module quad_steer_decoder
    import quad_pkg::*;
#(
    parameter int POS_W       = 8,
    parameter int HOLD_CYCLES = 22500
`ifdef QUAD_FILTER_EN
    ,
    parameter int FILT_CYCLES = 4
`endif
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             clr_err,
    output logic [POS_W-1:0] pos,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic             left,
    output logic             right
);

    localparam int               HW      = $clog2(HOLD_CYCLES + 1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    logic   a_cur;
    logic   b_cur;
    logic   a_valid;
    logic   b_valid;
    quad_t  cur;
    quad_t  prev;
    logic   primed;
    step_t  kind;
    logic   step_ok;
    logic [HW-1:0] hold_cnt;

    quad_sync_filter
`ifdef QUAD_FILTER_EN
        #(.FILT_CYCLES(FILT_CYCLES))
`endif
    u_sync_a (
        .CLK   (CLK),
        .reset (reset),
        .din   (quad_a),
        .dout  (a_cur),
        .valid (a_valid)
    );

    quad_sync_filter
`ifdef QUAD_FILTER_EN
        #(.FILT_CYCLES(FILT_CYCLES))
`endif
    u_sync_b (
        .CLK   (CLK),
        .reset (reset),
        .din   (quad_b),
        .dout  (b_cur),
        .valid (b_valid)
    );

    assign cur = {a_cur, b_cur};

    // NOTE: every variable assigned in an always_comb gets a default first;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        kind = STEP_NONE;
        if (primed) begin
            kind = quad_step(prev, cur);
        end
    end

    assign step_ok = (kind == STEP_FWD) || (kind == STEP_REV);

    // Compare stage. Until primed, the first qualified sample only seeds
    // prev, so inputs resting at any level during reset never look like a
    // transition.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            prev   <= 2'b00;
            primed <= 1'b0;
            pos    <= '0;
            step   <= 1'b0;
            dir    <= DIR_LEFT;
            err    <= 1'b0;
        end else begin
            step <= 1'b0;
            // A fresh illegal jump wins over a simultaneous clear.
            err  <= (err & ~clr_err) | (kind == STEP_ILLEGAL);
            if (a_valid && b_valid) begin
                prev   <= cur;
                primed <= 1'b1;
            end
            case (kind)
                STEP_FWD: begin
                    pos  <= pos + POS_ONE;
                    dir  <= DIR_RIGHT;
                    step <= 1'b1;
                end
                STEP_REV: begin
                    pos  <= pos - POS_ONE;
                    dir  <= DIR_LEFT;
                    step <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Hold stage. Loading HOLD_CYCLES-1 and clearing only on the cycle after
    // the counter has reached zero keeps left/right up for exactly
    // HOLD_CYCLES cycles. Both levels are written from the same step, so a
    // reversal swaps them on one edge and they are never high together.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            hold_cnt <= '0;
            left     <= 1'b0;
            right    <= 1'b0;
        end else if (step_ok) begin
            hold_cnt <= HW'(HOLD_CYCLES - 1);
            right    <= (kind == STEP_FWD);
            left     <= (kind == STEP_REV);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
        end else begin
            left     <= 1'b0;
            right    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_steer_decoder.sv
// ----------------------------------------------------------------------------
// tb_quad_steer_decoder
// Directed and randomized stimulus for quad_steer_decoder with a cycle-level
// reference model. The model keeps the driven phase state, a queue of input
// changes with the cycle at which each must become visible, and derives
// position/direction/error/hold levels from the Gray sequence order.
// Filter-specific steps are built when QUAD_FILTER_EN is defined.
// ----------------------------------------------------------------------------
module tb_quad_steer_decoder;

    localparam int HOLD = 16;
`ifdef QUAD_FILTER_EN
    localparam int FILT    = 4;
    localparam int LAT     = 3 + FILT;
    localparam int MIN_GAP = FILT + 1;
`else
    localparam int LAT     = 3;
    localparam int MIN_GAP = 1;
`endif

    logic       CLK = 1'b0;
    logic       reset;
    logic       quad_a;
    logic       quad_b;
    logic       clr_err;
    logic [7:0] pos;
    logic       step;
    logic       dir;
    logic       err;
    logic       left;
    logic       right;

    quad_steer_decoder #(
        .POS_W       (8),
        .HOLD_CYCLES (HOLD)
`ifdef QUAD_FILTER_EN
        ,
        .FILT_CYCLES (FILT)
`endif
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .quad_a  (quad_a),
        .quad_b  (quad_b),
        .clr_err (clr_err),
        .pos     (pos),
        .step    (step),
        .dir     (dir),
        .err     (err),
        .left    (left),
        .right   (right)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Forward order of phase states.
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic [1:0] in_state;
    logic [1:0] m_prev;
    logic [7:0] m_pos;
    logic       m_step;
    logic       m_dir;
    logic       m_err;
    logic       m_have;
    int         m_last;
    int         due_q [$];
    logic [1:0] val_q [$];

    function automatic int phase_of(input logic [1:0] s);
        for (int i = 0; i < 4; i++) begin
            if (seq[i] == s) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        logic exp_r;
        logic exp_l;
        exp_r = m_have && m_dir  && ((cyc - m_last) < HOLD);
        exp_l = m_have && !m_dir && ((cyc - m_last) < HOLD);
        chk("pos",   32'(pos),   32'(m_pos));
        chk("step",  32'(step),  32'(m_step));
        chk("dir",   32'(dir),   32'(m_dir));
        chk("err",   32'(err),   32'(m_err));
        chk("right", 32'(right), 32'(exp_r));
        chk("left",  32'(left),  32'(exp_l));
    endtask

    // Apply the input changes due at this edge to the model.
    task automatic apply_model();
        logic [1:0] v;
        int         d;
        logic       ill;
        m_step = 1'b0;
        ill    = 1'b0;
        while (due_q.size() > 0 && due_q[0] == cyc) begin
            v = val_q.pop_front();
            void'(due_q.pop_front());
            d = (phase_of(v) - phase_of(m_prev) + 4) % 4;
            if (d == 1 || d == 3) begin
                m_pos  = (d == 1) ? m_pos + 8'd1 : m_pos - 8'd1;
                m_dir  = (d == 1);
                m_step = 1'b1;
                m_have = 1'b1;
                m_last = cyc;
            end else if (d == 2) begin
                ill = 1'b1;
            end
            m_prev = v;
        end
        m_err = (m_err & ~clr_err) | ill;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (!reset) apply_model();
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // d = 1 forward, 3 reverse, 2 illegal jump.
    task automatic move(input int d);
        in_state = seq[(phase_of(in_state) + d) % 4];
        {quad_a, quad_b} = in_state;
        due_q.push_back(cyc + LAT);
        val_q.push_back(in_state);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        clr_err = 1'b0;
        #1;
        m_pos  = 8'h00;
        m_step = 1'b0;
        m_dir  = 1'b0;
        m_err  = 1'b0;
        m_have = 1'b0;
        due_q.delete();
        val_q.delete();
        check_all();
        idle(3);
        #3;
        reset  = 1'b0;
        m_prev = in_state;
        idle(8);
    endtask

    initial begin
        int d;
        int hl;

        // Reset released with A=B=1, inputs never move.
        reset    = 1'b1;
        clr_err  = 1'b0;
        in_state = 2'b11;
        {quad_a, quad_b} = in_state;
        do_reset();
        idle(20);
        chk("idle11_pos", 32'(pos), 32'h0);
        chk("idle11_err", 32'(err), 32'h0);

        // Four forward steps from 00, each visible exactly LAT cycles later.
        in_state = 2'b00;
        {quad_a, quad_b} = in_state;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            move(1);
            idle(LAT - 1);
            chk("step_early", 32'(step), 32'h0);
            tick();
            chk("step_at_lat", 32'(step), 32'h1);
            idle(10 - LAT);
        end
        chk("fwd4_pos",   32'(pos),   32'h4);
        chk("fwd4_dir",   32'(dir),   32'h1);
        chk("fwd4_right", 32'(right), 32'h1);
        chk("fwd4_left",  32'(left),  32'h0);

        // Drive position to 0x7F, then wrap forward and come back.
        while (m_pos != 8'h7F || due_q.size() > 0) begin
            if (m_pos + 8'(due_q.size()) != 8'h7F) move(1);
            idle(MIN_GAP);
        end
        idle(2);
        chk("pre_wrap", 32'(pos), 32'h7F);
        move(1);
        idle(LAT + 1);
        chk("wrap_up", 32'(pos), 32'h80);
        move(3);
        idle(LAT);
        chk("rev1_pos",   32'(pos),   32'h7F);
        chk("rev1_left",  32'(left),  32'h1);
        chk("rev1_right", 32'(right), 32'h0);
        idle(MIN_GAP + 1);
        move(3);
        idle(LAT + 1);
        chk("rev2_pos", 32'(pos), 32'h7E);

        // Illegal jumps and the clear interaction.
        move(2);
        idle(LAT + 1);
        chk("ill_err",  32'(err), 32'h1);
        chk("ill_pos",  32'(pos), 32'h7E);
        move(2);
        idle(LAT - 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_vs_ill", 32'(err), 32'h1);
        idle(3);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_alone", 32'(err), 32'h0);

        // Hold length after a single step, then reset in the middle of a hold.
        idle(HOLD + 4);
        do_reset();
        move(1);
        idle(LAT);
        hl = 0;
        for (int i = 0; i < 40 && right; i++) begin
            hl++;
            tick();
        end
        chk("hold_len", 32'(hl), 32'(HOLD));
        move(1);
        idle(LAT + 5);
        chk("mid_hold_right", 32'(right), 32'h1);
        do_reset();

`ifdef QUAD_FILTER_EN
        // Short glitch on A is swallowed; a long-enough change steps at 3+FILT.
        quad_a = ~in_state[1];
        idle(2);
        quad_a = in_state[1];
        idle(15);
        chk("glitch_pos",  32'(pos), 32'h0);
        chk("glitch_err",  32'(err), 32'h0);
        move(1);
        idle(LAT - 1);
        chk("filt_early", 32'(step), 32'h0);
        tick();
        chk("filt_step",  32'(step), 32'h1);
        idle(10);
`endif

        // Randomized walk with occasional illegal jumps and clears.
        for (int i = 0; i < 400; i++) begin
            d = $urandom_range(0, 9);
            move((d == 0) ? 2 : ((d <= 5) ? 1 : 3));
            if ($urandom_range(0, 7) == 0) begin
                clr_err = 1'b1;
                tick();
                clr_err = 1'b0;
            end
            idle($urandom_range(MIN_GAP, MIN_GAP + 20));
        end
        idle(LAT + HOLD + 2);
        chk("final_right", 32'(right), 32'h0);
        chk("final_left",  32'(left),  32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
